// File: rtl/delay_line_sequencer.sv
// Delay-line sequencer: streams audio samples through a single-port SRAM used as a
// circular buffer. Each accepted strobe does one optional read (delayed sample), one
// capture and one optional write (new sample). After reset the whole SRAM is zeroed.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   en, sample_stb           accept a sample when both high in IDLE
//   sample_in, delay_len     sample to store, delay in samples
//   freeze                   suppress the SRAM write (loop playback)
//   ovr_clr                  clear the sticky overrun flag
//   sram_csb/web/addr/din    SRAM control (active-low select / write enable)
//   sram_dout                SRAM read data, valid the cycle after a read
//   sample_out(_vld)         delayed sample and its one-cycle update pulse
//   busy, overrun            not-IDLE indicator, sticky dropped-strobe flag
module delay_line_sequencer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en,
    input  logic              sample_stb,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              freeze,
    input  logic              ovr_clr,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_vld,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {StClr, StIdle, StRd, StCap, StWr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] dly_q, dly_d;
    logic              frz_q, frz_d;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic [DATA_W-1:0] sample_out_q, sample_out_d;
    logic              overrun_q, overrun_d;

    logic              stb_ok;
    logic [ADDR_W-1:0] rd_addr;

    assign stb_ok  = en & sample_stb;
    // Natural ADDR_W-bit wrap gives the modulo-DEPTH read address.
    assign rd_addr = wr_ptr_q - dly_q;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        dly_d        = dly_q;
        frz_d        = frz_q;
        smp_d        = smp_q;
        sample_out_d = sample_out_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            StClr: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == '1) state_d = StIdle;
            end
            StIdle: begin
                if (stb_ok) begin
                    smp_d   = sample_in;
                    dly_d   = delay_len;
                    frz_d   = freeze;
                    state_d = StRd;
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                sample_out_d = (dly_q == '0) ? smp_q : sram_dout;
                state_d      = StWr;
            end
            StWr: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                state_d  = StIdle;
            end
            default: state_d = StClr;
        endcase

        // A new drop wins over a simultaneous clear.
        if (stb_ok && (state_q != StIdle)) overrun_d = 1'b1;
        else if (ovr_clr)                  overrun_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= StClr;
            clr_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            dly_q        <= '0;
            frz_q        <= 1'b0;
            smp_q        <= '0;
            sample_out_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            dly_q        <= dly_d;
            frz_q        <= frz_d;
            smp_q        <= smp_d;
            sample_out_q <= sample_out_d;
            overrun_q    <= overrun_d;
        end
    end

    // SRAM strobes decoded from the registered state and pointers.
    always_comb begin
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        unique case (state_q)
            StClr: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = clr_cnt_q;
            end
            StRd: begin
                if (dly_q != '0) begin
                    sram_csb  = 1'b0;
                    sram_addr = rd_addr;
                end
            end
            StWr: begin
                if (!frz_q) begin
                    sram_csb  = 1'b0;
                    sram_web  = 1'b0;
                    sram_addr = wr_ptr_q;
                    sram_din  = smp_q;
                end
            end
            default: ;
        endcase
    end

    assign sample_out     = sample_out_q;
    assign sample_out_vld = (state_q == StWr);
    assign busy           = (state_q != StIdle);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Bench for delay_line_sequencer: SRAM behavioural model, reference buffer model and
// an expected-output queue popped on every sample_out_vld pulse.
module tb_delay_line_sequencer;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 256;

    logic          wb_clk_i   = 1'b0;
    logic          wb_rst_i   = 1'b1;
    logic          en         = 1'b0;
    logic          sample_stb = 1'b0;
    logic          freeze     = 1'b0;
    logic          ovr_clr    = 1'b0;
    logic [DW-1:0] sample_in  = '0;
    logic [AW-1:0] delay_len  = '0;
    logic          sram_csb, sram_web, sample_out_vld, busy, overrun;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout, sample_out;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    logic [AW-1:0] wp_ref = '0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_out = '0;
    logic [DW-1:0] mon_exp;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    delay_line_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .en            (en),
        .sample_stb    (sample_stb),
        .sample_in     (sample_in),
        .delay_len     (delay_len),
        .freeze        (freeze),
        .ovr_clr       (ovr_clr),
        .sram_csb      (sram_csb),
        .sram_web      (sram_web),
        .sram_addr     (sram_addr),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout),
        .sample_out    (sample_out),
        .sample_out_vld(sample_out_vld),
        .busy          (busy),
        .overrun       (overrun)
    );

    // Synchronous single-port SRAM, read data one cycle after the read.
    always @(posedge wb_clk_i) begin
        if (!sram_csb) begin
            if (!sram_web) sram_mem[sram_addr] <= sram_din;
            else           sram_dout <= sram_mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pop on each vld pulse, otherwise sample_out must hold.
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            last_out = sample_out;
        end else if (sample_out_vld) begin
            if (exp_q.size() == 0) begin
                chk("vld_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sample_out", sample_out, mon_exp);
            end
            last_out = sample_out;
        end else begin
            chk("sample_out_hold", sample_out, last_out);
        end
    end

    // One strobe sequence, N0 = strobe cycle, N1 = RD, N2 = CAP, N3 = WR.
    task automatic strobe(input logic [DW-1:0] s, input logic [AW-1:0] d, input logic f,
                          input bit dup, input bit clr, input bit en_drop,
                          output logic [AW-1:0] rd_obs);
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        @(negedge wb_clk_i);
        chk("idle_busy", busy, 1'b0);
        sample_stb = 1'b1;
        sample_in  = s;
        delay_len  = d;
        freeze     = f;
        ra = wp_ref - d;
        wa = wp_ref;
        exp_q.push_back((d == 0) ? s : ref_mem[ra]);
        if (!f) ref_mem[wp_ref] = s;
        wp_ref = wp_ref + 1'b1;
        @(negedge wb_clk_i);
        // Scramble inputs: the latched copies must be used.
        sample_stb = 1'b0;
        sample_in  = ~s;
        delay_len  = ~d;
        freeze     = ~f;
        if (en_drop) en = 1'b0;
        if (d == 0) begin
            chk("rd_csb_d0", sram_csb, 1'b1);
        end else begin
            chk("rd_csb", sram_csb, 1'b0);
            chk("rd_web", sram_web, 1'b1);
            chk("rd_addr", sram_addr, ra);
        end
        rd_obs = sram_addr;
        @(negedge wb_clk_i);
        chk("cap_csb", sram_csb, 1'b1);
        chk("cap_vld", sample_out_vld, 1'b0);
        if (dup) sample_stb = 1'b1;
        if (clr) ovr_clr = 1'b1;
        @(negedge wb_clk_i);
        sample_stb = 1'b0;
        ovr_clr    = 1'b0;
        en         = 1'b1;
        chk("wr_vld", sample_out_vld, 1'b1);
        if (f) begin
            chk("wr_frozen_csb", sram_csb, 1'b1);
        end else begin
            chk("wr_csb", sram_csb, 1'b0);
            chk("wr_web", sram_web, 1'b0);
            chk("wr_addr", sram_addr, wa);
            chk("wr_din", sram_din, s);
        end
        if (dup) chk("dup_overrun", overrun, 1'b1);
    endtask

    initial begin
        logic [AW-1:0] rd;
        int            n;
        bit            ok;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        wb_rst_i = 1'b1;
        en       = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy", busy, 1'b1);
        chk("rst_vld", sample_out_vld, 1'b0);
        chk("rst_out", sample_out, 16'h0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_csb", sram_csb, 1'b0);
        chk("rst_addr", sram_addr, 8'h0);

        // Clear sweep after release.
        wb_rst_i = 1'b0;
        n  = 0;
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_addr !== n[AW-1:0] ||
                sram_din !== '0) ok = 1'b0;
            n++;
            @(negedge wb_clk_i);
        end
        chk("clr_sweep_writes", ok, 1'b1);
        chk("clr_sweep_len", n, 256);
        chk("clr_done_busy", busy, 1'b0);

        // Strobe with en low is ignored.
        en = 1'b0;
        sample_stb = 1'b1;
        @(negedge wb_clk_i);
        sample_stb = 1'b0;
        en = 1'b1;
        chk("en_low_busy", busy, 1'b0);
        chk("en_low_ovr", overrun, 1'b0);

        // delay 4, ramp 1..10 every 8 cycles; en dropped mid-sequence on odd steps.
        for (int i = 0; i < 10; i++) begin
            strobe(DW'(i + 1), 8'd4, 1'b0, 1'b0, 1'b0, (i % 2) == 1, rd);
            repeat (4) @(negedge wb_clk_i);
        end

        // Zero delay bypasses the read.
        strobe(16'h1234, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, rd);

        // Overrun from a second strobe 2 cycles later, then clear.
        strobe(16'h0055, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, rd);
        @(negedge wb_clk_i);
        ovr_clr = 1'b1;
        @(negedge wb_clk_i);
        ovr_clr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);
        // Drop and clear together: set wins.
        strobe(16'h0066, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, rd);
        @(negedge wb_clk_i);
        ovr_clr = 1'b1;
        @(negedge wb_clk_i);
        ovr_clr = 1'b0;
        chk("ovr_cleared2", overrun, 1'b0);

        // Fill with ramp 0..255, then loop it back frozen with delay 255.
        for (int i = 0; i < 256; i++) strobe(DW'(i), 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, rd);
        for (int i = 0; i < 256; i++)
            strobe(DW'(16'hA000 + i), 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, rd);

        // Advance to wr_ptr=1 through the 255->0 wrap, then delay 3 reads address 254.
        for (int i = 0; i < 300; i++) begin
            if (wp_ref == 8'd1) break;
            strobe(DW'(16'h3000 + i), 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, rd);
        end
        strobe(16'h7777, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, rd);
        chk("wrap_rd_addr", rd, 8'd254);

        // Reset asserted in CAP abandons the sequence; a strobe in RD sets overrun first.
        @(negedge wb_clk_i);
        sample_stb = 1'b1;
        sample_in  = 16'h4242;
        delay_len  = 8'd1;
        freeze     = 1'b0;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        sample_stb = 1'b0;
        chk("rd_drop_ovr", overrun, 1'b1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("cap_rst_vld", sample_out_vld, 1'b0);
        chk("cap_rst_busy", busy, 1'b1);
        chk("cap_rst_csb", sram_csb, 1'b0);
        chk("cap_rst_addr", sram_addr, 8'h0);
        chk("cap_rst_out", sample_out, 16'h0);
        chk("cap_rst_ovr", overrun, 1'b0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        wp_ref = '0;

        // Strobe during the clear sweep is dropped.
        repeat (3) @(negedge wb_clk_i);
        sample_stb = 1'b1;
        @(negedge wb_clk_i);
        sample_stb = 1'b0;
        chk("clr_drop_ovr", overrun, 1'b1);
        chk("clr_drop_busy", busy, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            @(negedge wb_clk_i);
        end
        chk("clr2_done", busy, 1'b0);
        ovr_clr = 1'b1;
        @(negedge wb_clk_i);
        ovr_clr = 1'b0;
        chk("ovr_cleared3", overrun, 1'b0);

        // Buffer is zero again after the sweep.
        strobe(16'hBEEF, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, rd);
        strobe(16'h0077, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, rd);

        repeat (4) @(negedge wb_clk_i);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_sequencer.md
DELAY_LINE_SEQUENCER -- requirements
Module: delay_line_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning SRAM address width (DEPTH = 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning audio sample width.
REQ-003 SHALL have port wb_clk_i  in  1  meaning the single clock for all logic.
REQ-004 SHALL have port wb_rst_i  in  1  meaning reset, which is synchronous and active-high.
REQ-005 SHALL have port en  in  1  meaning sequencer enable; when low, sample_stb is ignored.
REQ-006 SHALL have port sample_stb  in  1  meaning a one-cycle pulse per audio sample, synchronous to wb_clk_i.
REQ-007 SHALL have port sample_in  in  DATA_W  meaning the audio sample to store.
REQ-008 SHALL have port delay_len  in  ADDR_W  meaning delay in samples, 0..DEPTH-1.
REQ-009 SHALL have port freeze  in  1  meaning suppress SRAM writes (loop playback).
REQ-010 SHALL have port ovr_clr  in  1  meaning clear the sticky overrun flag.
REQ-011 SHALL have port sram_csb  out  1  meaning SRAM chip select, active-low.
REQ-012 SHALL have port sram_web  out  1  meaning SRAM write enable, active-low.
REQ-013 SHALL have port sram_addr  out  ADDR_W  meaning the SRAM address.
REQ-014 SHALL have port sram_din  out  DATA_W  meaning SRAM write data.
REQ-015 SHALL have port sram_dout  in  DATA_W  meaning SRAM read data, valid the cycle after a read is issued.
REQ-016 SHALL have port sample_out  out  DATA_W  meaning the delayed sample.
REQ-017 SHALL have port sample_out_vld  out  1  meaning a one-cycle pulse when sample_out updates.
REQ-018 SHALL have port busy  out  1  meaning high in every state except IDLE.
REQ-019 SHALL have port overrun  out  1  meaning sticky flag: a strobe was dropped.

Function
REQ-020 SHALL implement the states CLR, IDLE, RD, CAP and WR; sram_* outputs SHALL be decoded from the state and registered pointers.
REQ-021 CLR: sram_csb=0, sram_web=0, sram_din=0, sram_addr=clr_cnt; clr_cnt runs 0..DEPTH-1, one address per cycle, then the state goes to IDLE.
REQ-022 IDLE: sram_csb=1, sram_web=1; with en=1 and sample_stb=1, latch sample_in, delay_len and freeze, then go to RD.
REQ-023 RD: if the latched delay is not 0, drive sram_csb=0, sram_web=1, sram_addr=(wr_ptr - delay) mod DEPTH; if the latched delay is 0, keep sram_csb=1. The state then goes to CAP.
REQ-024 CAP: sram_csb=1; at the end of the cycle, register sample_out from sram_dout, or from the latched sample if the delay is 0. The state then goes to WR.
REQ-025 WR: sample_out_vld=1. If freeze was not latched, drive sram_csb=0, sram_web=0, sram_addr=wr_ptr, sram_din=latched sample; otherwise keep sram_csb=1. wr_ptr increments mod DEPTH in both cases, and the state goes to IDLE.
REQ-026 Latency: sample_out_vld SHALL assert 3 clock edges after the edge that samples sample_stb, for exactly 1 cycle; the minimum strobe spacing is 4 cycles.
REQ-027 A sample_stb in any state other than IDLE (with en=1) SHALL be dropped and SHALL set overrun; the sequence in progress continues unchanged.
REQ-028 ovr_clr SHALL clear overrun; if ovr_clr and a new overrun occur in the same cycle, overrun SHALL be set.
REQ-029 Deasserting en mid-sequence SHALL let the current sequence complete.
REQ-030 wr_ptr wraps from DEPTH-1 to 0; read-address subtraction wraps modulo DEPTH.
REQ-031 Changes to delay_len or freeze outside IDLE SHALL NOT affect the sequence in progress.
REQ-032 sample_out SHALL hold its value between sample_out_vld pulses.

Reset
REQ-033 With wb_rst_i=1, the block SHALL be in CLR with clr_cnt=0, wr_ptr=0, sample_out=0, sample_out_vld=0 and overrun=0; this applies mid-sequence too, and the sequence in progress is abandoned.
REQ-034 After wb_rst_i deasserts, the CLR sweep SHALL run DEPTH cycles before IDLE, with busy=1 throughout. Strobes during CLR are dropped and set overrun.

Verification
REQ-035 Reset release -> 256 write cycles, addr 0..255, din=0, busy high for exactly 256 cycles, then IDLE with busy=0.
REQ-036 delay_len=4; inputs 1..10 strobed every 8 cycles -> sample_out sequence 0,0,0,0,1,2,3,4,5,6; each vld pulse arrives 3 edges after its strobe.
REQ-037 delay_len=0; input 0x1234 -> sample_out=0x1234, with no read cycle (sram_csb stays high in RD), and the write to wr_ptr still occurs.
REQ-038 Two strobes 2 cycles apart -> second strobe dropped, overrun=1, wr_ptr advances by 1; ovr_clr pulse -> overrun=0.
REQ-039 delay_len=3, after 257 strobes (wr_ptr=1) -> read address 254; wr_ptr wraps 255->0.
REQ-040 freeze=1 for 256 strobes after filling the buffer with ramp 0..255 (delay_len=0 during fill) then delay_len=255 -> no write cycles occur, and output repeats the stored ramp; wb_rst_i asserted in CAP -> next state CLR, sample_out_vld never asserted.
